// File: rtl/hsid_pkg.sv
// Shared types and constants for the HSID MSE ranking blocks.
package hsid_pkg;

  localparam int unsigned HSID_WORD_WIDTH       = 32;
  localparam int unsigned HSID_MAX_HSP_LIBRARY  = 64;
  localparam int unsigned HSID_REF_WIDTH        = $clog2(HSID_MAX_HSP_LIBRARY);
  localparam int unsigned HSID_MSE_TOPK_DEFAULT = 4;

  typedef struct packed {
    logic [HSID_WORD_WIDTH-1:0] value;
    logic [HSID_REF_WIDTH-1:0]  ref_id;
  } hsid_mse_entry_t;

  typedef enum logic [1:0] {
    HSID_TOPK_IDLE  = 2'd0,
    HSID_TOPK_ACCUM = 2'd1,
    HSID_TOPK_DONE  = 2'd2
  } hsid_topk_state_e;

endpackage

// File: rtl/hsid_mse_topk_slot.sv
// One ranked slot of the top-K list: holds, takes the upper neighbour, or takes the input.
module hsid_mse_topk_slot
  import hsid_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = HSID_WORD_WIDTH,
  parameter int unsigned REF_WIDTH  = HSID_REF_WIDTH,
  parameter int unsigned SELECT_MAX = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  filled,
  input  logic                  prev_better,
  input  logic [WORD_WIDTH-1:0] prev_value,
  input  logic [REF_WIDTH-1:0]  prev_ref,
  input  logic [WORD_WIDTH-1:0] in_value,
  input  logic [REF_WIDTH-1:0]  in_ref,
  output logic [WORD_WIDTH-1:0] value,
  output logic [REF_WIDTH-1:0]  ref_id,
  output logic                  better_c
);

  localparam logic [WORD_WIDTH-1:0] SENTINEL =
    (SELECT_MAX != 0) ? {WORD_WIDTH{1'b0}} : {WORD_WIDTH{1'b1}};

  // Strict compare: an equal input lands ahead of this entry; empty slots never win
  always_comb begin
    better_c = 1'b0;
    if (filled) begin
      if (SELECT_MAX != 0) better_c = (value > in_value);
      else                 better_c = (value < in_value);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      value  <= SENTINEL;
      ref_id <= '0;
    end else if (load && !better_c) begin
      if (prev_better) begin
        value  <= in_value;
        ref_id <= in_ref;
      end else begin
        value  <= prev_value;
        ref_id <= prev_ref;
      end
    end
  end

endmodule

// File: rtl/hsid_mse_topk.sv
// Sorted top-K tracker of MSE scores with library refs over one sweep.
// Optional HSID_MSE_TOPK_STATS_EN adds per-sweep sample/drop counters.
module hsid_mse_topk
  import hsid_pkg::*;
#(
  parameter int unsigned WORD_WIDTH       = HSID_WORD_WIDTH,
  parameter int unsigned HSI_LIBRARY_SIZE = HSID_MAX_HSP_LIBRARY,
  parameter int unsigned TOP_K            = HSID_MSE_TOPK_DEFAULT,
  parameter int unsigned SELECT_MAX       = 0,
  localparam int unsigned REF_WIDTH       = $clog2(HSI_LIBRARY_SIZE),
  localparam int unsigned CNT_WIDTH       = $clog2(TOP_K + 1),
  localparam int unsigned STAT_WIDTH      = REF_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_WIDTH-1:0]       in_value,
  input  logic [REF_WIDTH-1:0]        in_ref,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [TOP_K*WORD_WIDTH-1:0] out_values,
  output logic [TOP_K*REF_WIDTH-1:0]  out_refs,
  output logic [CNT_WIDTH-1:0]        out_count,
  output logic                        busy
`ifdef HSID_MSE_TOPK_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0]       sample_count,
  output logic [STAT_WIDTH-1:0]       dropped_count
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'(HSID_TOPK_IDLE);
  localparam logic [1:0] ST_ACCUM = 2'(HSID_TOPK_ACCUM);
  localparam logic [1:0] ST_DONE  = 2'(HSID_TOPK_DONE);

  logic [1:0] state;
  logic [1:0] state_next;

  logic accept_c;
  logic transfer_c;
  logic flush_c;
  logic drop_c;

  logic [TOP_K-1:0]      better_c;
  logic [WORD_WIDTH-1:0] slot_value [TOP_K];
  logic [REF_WIDTH-1:0]  slot_ref   [TOP_K];

  assign accept_c   = in_valid && in_ready && !clear;
  assign transfer_c = out_valid && out_ready;
  assign flush_c    = clear || transfer_c;
  assign drop_c     = better_c[TOP_K-1];

  // Slot i compares itself against the input; slot 0 sees an always-better virtual neighbour
  for (genvar i = 0; i < TOP_K; i++) begin : g_slot
    logic                  prev_better;
    logic [WORD_WIDTH-1:0] prev_value;
    logic [REF_WIDTH-1:0]  prev_ref;

    if (i == 0) begin : g_head
      assign prev_better = 1'b1;
      assign prev_value  = in_value;
      assign prev_ref    = in_ref;
    end else begin : g_tail
      assign prev_better = better_c[i-1];
      assign prev_value  = slot_value[i-1];
      assign prev_ref    = slot_ref[i-1];
    end

    hsid_mse_topk_slot #(
      .WORD_WIDTH (WORD_WIDTH),
      .REF_WIDTH  (REF_WIDTH),
      .SELECT_MAX (SELECT_MAX)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush_c),
      .load        (accept_c),
      .filled      (CNT_WIDTH'(i) < out_count),
      .prev_better (prev_better),
      .prev_value  (prev_value),
      .prev_ref    (prev_ref),
      .in_value    (in_value),
      .in_ref      (in_ref),
      .value       (slot_value[i]),
      .ref_id      (slot_ref[i]),
      .better_c    (better_c[i])
    );

    assign out_values[i*WORD_WIDTH +: WORD_WIDTH] = slot_value[i];
    assign out_refs[i*REF_WIDTH +: REF_WIDTH]     = slot_ref[i];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst || clear) state <= ST_IDLE;
    else              state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept_c) state_next = in_last ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (accept_c && in_last) state_next = ST_DONE;
      ST_DONE:  if (transfer_c) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered handshake/status outputs follow the next state
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_count <= '0;
    end else begin
      in_ready  <= (state_next != ST_DONE);
      out_valid <= (state_next == ST_DONE);
      busy      <= (state_next != ST_IDLE);
      if (transfer_c)
        out_count <= '0;
      else if (accept_c && !drop_c && out_count != CNT_WIDTH'(TOP_K))
        out_count <= out_count + CNT_WIDTH'(1);
    end
  end

`ifdef HSID_MSE_TOPK_STATS_EN
  // Saturating per-sweep counters, frozen in DONE since nothing is accepted there
  always_ff @(posedge clk) begin
    if (rst || flush_c) begin
      sample_count  <= '0;
      dropped_count <= '0;
    end else if (accept_c) begin
      if (sample_count != {STAT_WIDTH{1'b1}})
        sample_count <= sample_count + STAT_WIDTH'(1);
      if (drop_c && dropped_count != {STAT_WIDTH{1'b1}})
        dropped_count <= dropped_count + STAT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: doc/hsid_mse_topk.md
Name: hsid_mse_topk

Overview:
- Parametrised successor of the single min/max MSE comparator.
- Keeps a sorted list of the TOP_K best MSE scores and their library references over one library sweep.
- Sits after the MSE accumulator. The sweep is delimited by in_last; the result is handed to the downstream classifier/readout over a valid/ready handshake.
- SELECT_MAX picks between best = smallest (classification) and best = largest (outlier detection).

Parameters:
- WORD_WIDTH, HSID_WORD_WIDTH (32): MSE value width.
- HSI_LIBRARY_SIZE, HSID_MAX_HSP_LIBRARY: number of library references. REF_WIDTH = $clog2(HSI_LIBRARY_SIZE).
- TOP_K, 4: number of ranked slots. Legal range 1..16.
- SELECT_MAX, 0: 0 keeps the K smallest scores, 1 keeps the K largest.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear of list and FSM.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_value  in  WORD_WIDTH  MSE score.
- in_ref  in  REF_WIDTH  library index of the score.
- in_last  in  1  marks the last sample of the sweep.
- out_valid  out  1  ranked result available.
- out_ready  in  1  consumer takes the result.
- out_values  out  TOP_K*WORD_WIDTH  slot i at bits [i*WORD_WIDTH +: WORD_WIDTH]; slot 0 = best.
- out_refs  out  TOP_K*REF_WIDTH  refs, same packing as out_values.
- out_count  out  $clog2(TOP_K+1)  number of filled slots.
- busy  out  1  high in ACCUM and DONE.

Behaviour:
- Reset and clear:
  - rst has priority over clear; clear has priority over everything else.
  - Both force: state IDLE; all slot values = sentinel (all-ones if SELECT_MAX=0, zero if 1); refs 0; out_count 0; out_valid 0.
  - A sample presented in the same cycle as rst or clear is discarded.
- Handshake:
  - Sample accepted when in_valid && in_ready. in_ready = 1 in IDLE/ACCUM, 0 in DONE.
  - Result transferred when out_valid && out_ready.
- FSM:
  - IDLE: accept without in_last -> ACCUM; accept with in_last -> DONE.
  - ACCUM: accept with in_last -> DONE.
  - DONE: out_valid=1 and all outputs held stable. On result transfer -> IDLE; slots restored to sentinel and count cleared on the same edge.
- Insertion (one accepted sample per cycle, registered, 1-cycle latency):
  - p = number of filled slots strictly better than in_value ("better" is < for min, > for max).
  - Ties: the new entry goes ahead of equal entries (newest wins), matching the existing <= / >= comparator rule.
  - If p < TOP_K: slots p..TOP_K-2 shift to p+1..TOP_K-1, the new value/ref is written at slot p, and out_count = min(out_count+1, TOP_K).
  - If p == TOP_K: the sample is dropped and the count is unchanged.
  - An empty (unfilled) slot is always worse than any input, so a sentinel-valued input still fills an empty slot.
- Outputs:
  - out_values/out_refs drive slot registers directly. They are meaningful only while out_valid; intermediate ranking is visible in ACCUM for debug.
  - out_valid rises the cycle after the in_last sample is accepted.
  - Unfilled slots read as sentinel, ref 0.
- Boundaries:
  - Sweep of fewer than TOP_K samples: out_count < TOP_K and trailing slots hold sentinel.
  - No range check on in_ref.
  - TOP_K=1 degenerates to the single min (or max) tracker with ref.

Optional Feature:
- Macro HSID_MSE_TOPK_STATS_EN.
- Defined:
  - Adds output sample_count (REF_WIDTH+1 bits): samples accepted this sweep, saturating at all-ones.
  - Adds output dropped_count (same width): samples rejected because p == TOP_K.
  - Both are cleared by rst, clear and result transfer, and are held in DONE.
- Undefined: ports and counters are absent; no other behaviour changes.

Decomposition:
- Package hsid_pkg gains:
  - typedef hsid_mse_entry_t struct {value, ref}.
  - enum hsid_topk_state_e {IDLE, ACCUM, DONE}.
  - constant HSID_MSE_TOPK_DEFAULT=4.
- Sub-module hsid_mse_topk_slot: one ranked slot. Computes its own "better" flag and selects hold / take neighbour / take input. The top level generates TOP_K of these plus the FSM.

Test Plan (TOP_K=4, SELECT_MAX=0, WORD_WIDTH=32):
- Reset/rst mid-ACCUM:
  - rst high -> out_valid=0, out_count=0, all out_values=FFFFFFFF, refs 0, in_ready=1.
  - Assert rst mid-ACCUM -> same state the next cycle.
- Full sweep: send 500@1, 200@2, 900@3, 100@4, 300@5, 50@6 (last).
  - -> out_valid the next cycle.
  - -> values 50,100,200,300; refs 6,4,2,5; out_count=4.
- Tie ordering: send 0x10@1, 0x10@2, 0x10@3 (last) -> values 10,10,10,FFFFFFFF; refs 3,2,1,0; count 3.
- Backpressure and turnaround:
  - Hold out_ready=0 for 5 cycles -> in_ready=0, outputs stable.
  - Release -> IDLE next cycle.
  - New sweep 7@9 (last) -> slot0=7/ref9, count 1.
- Clear: clear asserted together with a valid sample in ACCUM -> sample discarded, list reset, state IDLE.
- Randomised sweep: 50 random values with random in_valid gaps, both SELECT_MAX settings -> list matches a sorted scoreboard model.
  - With STATS_EN: sample_count=50 and dropped_count matches the model.
